ascii_sum_sequencer: RTL and testbench
======================================

# ascii_sum_sequencer

Serial front-end controller for the two-digit ASCII adder datapath. It accepts a stream of 7-bit ASCII characters of the form `A+B=`, assembles the tens/units operand digits, and presents them to the adder's AD/AU/BD/BU inputs. It then captures the adder's three-digit ASCII result and emits it as a serial character stream with a valid/ready handshake. It sits between a character source (UART/keypad decoder) and a character sink.

## Interface
- No parameters.
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- rx_data  in  7  incoming ASCII character.
- rx_valid  in  1  rx_data valid this cycle.
- rx_ready  out  1  block accepts a character this cycle; transfer when rx_valid && rx_ready.
- AD, AU, BD, BU  out  7 each  registered ASCII operand digits driven to the adder.
- YC, YD, YU  in  7 each  ASCII result digits from the adder (combinational from AD..BU).
- tx_data  out  7  outgoing ASCII character.
- tx_valid  out  1  tx_data valid; transfer when tx_valid && tx_ready.
- tx_ready  in  1  sink accepts tx_data.
- err  out  1  one-cycle pulse on a syntax error.

## Operation
- Digit = 0x30..0x39; '+' = 0x2B; '=' = 0x3D; space 0x20 is accepted and ignored in every input state (no state change).
- States: A0, A1, A2, B0, B1, B2, LATCH, SEND.
- rx_ready = 1 in A0..B2, 0 in LATCH and SEND. Characters are consumed only on accepted transfers.
- Digit entry shifts digits in:
  - The first digit sets units = d and tens = 0x30.
  - The second digit sets tens = old units and units = d.
- A0: digit → AU=d, AD=0x30, go to A1. Anything else (except space) → error.
- A1: digit → AD=AU, AU=d, go to A2. '+' → B0. Else error.
- A2: '+' → B0. Else error (this includes a third digit).
- B0/B1/B2: same as A0/A1/A2 on BU/BD, with '=' in place of '+'; '=' goes to LATCH.
- LATCH: capture YC, YD, YU into result registers R2, R1, R0, clear the index idx=0, go to SEND.
- SEND: tx_data = R2, R1, R0, 0x0D for idx = 0, 1, 2, 3.
  - On each accepted transfer, idx++.
  - On acceptance at idx=3: AD=AU=BD=BU=0x30, go to A0.
- Error (any illegal char accepted in A0..B2):
  - err=1 for exactly one cycle.
  - All four operands return to 0x30; state returns to A0.
  - The offending character is consumed.
- The adder sees stable operands from the last B digit through LATCH. YC..YU are sampled only in LATCH.
- idx is a 2-bit counter; no wrap is reachable because SEND exits at idx=3.

## Timing
- Reset values:
  - State A0, so rx_ready=1.
  - AD=AU=BD=BU=0x30.
  - R2..R0=0x30, idx=0.
  - tx_valid=0, tx_data=0x00, err=0.
- rst wins over all other inputs in any state, including mid-SEND. Any pending tx character is dropped, with tx_valid=0 on the cycle after the reset edge.
- Operand registers update on the clock edge of the accepting transfer.
- Latency from the edge that accepts '=': the next edge is LATCH, which captures the result. tx_valid=1 from the following cycle, i.e. 2 edges after '=' acceptance.
- tx_valid = (state==SEND), registered-state decode.
  - tx_data and tx_valid are held stable while tx_valid && !tx_ready.
  - With tx_ready held at 1, the four characters leave on 4 consecutive cycles.
- After the 0x0D is accepted, rx_ready=1 on the next cycle. Minimum frame period = 6 input transfers + 1 LATCH + 4 output transfers.
- err is asserted in the cycle after the offending transfer edge (registered), and the state is A0 in that same cycle.
- rx_valid while rx_ready=0 is ignored; no buffering.

## Test plan
- Input "12+34=", tx_ready=1 → tx sequence 0x30,0x34,0x36,0x0D ("046\r"); tx_valid first high 2 edges after '=' accepted; err never asserted.
- Input "99+99=" → "198\r"; input "7+5=" → AD=0x30, AU=0x37, BD=0x30, BU=0x35 at LATCH, output "012\r"; input "0 1+ 2=" (spaces) → "003\r".
- Input "123" → err pulse one cycle after '3' accepted, operands 0x30, state A0; then "4+4=" → "008\r". Also cover "+", "5+=", "A".
- Backpressure during SEND: tx_ready low 3 cycles at idx=1 → tx_data stays 0x34 with tx_valid=1; rx_valid pulses are not accepted; sequence completes unchanged.
- rst asserted during SEND at idx=2 → next cycle tx_valid=0, rx_ready=1, operands 0x30; "1+1=" then yields "002\r".
- rst asserted after "5" in B1 → state A0, BU=0x30; no err pulse.

Source files
------------

// File: rtl/ascii_sum_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : ascii_sum_sequencer
//  Description : Serial front-end for the two-digit ASCII adder. Parses an
//                "A+B=" character stream into tens/units operand digits,
//                drives them to the adder, captures the three-digit result
//                and streams it back out followed by a carriage return.
//  Ports       : clk, rst          - clock, synchronous active-high reset
//                rx_data/valid/ready - inbound 7-bit ASCII, valid/ready
//                AD, AU, BD, BU    - registered ASCII operand digits
//                YC, YD, YU        - ASCII result digits from the adder
//                tx_data/valid/ready - outbound 7-bit ASCII, valid/ready
//                err               - one-cycle pulse on a syntax error
//  Revision    : 1.0 - initial release
// ============================================================================
module ascii_sum_sequencer (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] rx_data,
    input  logic       rx_valid,
    output logic       rx_ready,
    output logic [6:0] AD,
    output logic [6:0] AU,
    output logic [6:0] BD,
    output logic [6:0] BU,
    input  logic [6:0] YC,
    input  logic [6:0] YD,
    input  logic [6:0] YU,
    output logic [6:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       err
);

    localparam logic [6:0] c_ZERO  = 7'h30;
    localparam logic [6:0] c_NINE  = 7'h39;
    localparam logic [6:0] c_PLUS  = 7'h2B;
    localparam logic [6:0] c_EQ    = 7'h3D;
    localparam logic [6:0] c_SPACE = 7'h20;
    localparam logic [6:0] c_CR    = 7'h0D;

    typedef enum logic [2:0] {
        S_A0    = 3'd0,
        S_A1    = 3'd1,
        S_A2    = 3'd2,
        S_B0    = 3'd3,
        S_B1    = 3'd4,
        S_B2    = 3'd5,
        S_LATCH = 3'd6,
        S_SEND  = 3'd7
    } state_t;

    state_t     r_state_q, w_state_d;
    logic [6:0] r_ad_q, w_ad_d, r_au_q, w_au_d;
    logic [6:0] r_bd_q, w_bd_d, r_bu_q, w_bu_d;
    logic [6:0] r_r2_q, w_r2_d, r_r1_q, w_r1_d, r_r0_q, w_r0_d;
    logic [1:0] r_idx_q, w_idx_d;
    logic       r_err_q, w_err_d;

    logic       w_fire;
    logic       w_is_digit;
    logic       w_bad;

    assign rx_ready   = (r_state_q != S_LATCH) && (r_state_q != S_SEND);
    assign tx_valid   = (r_state_q == S_SEND);
    assign w_fire     = rx_valid && rx_ready;
    assign w_is_digit = (rx_data >= c_ZERO) && (rx_data <= c_NINE);

    assign AD  = r_ad_q;
    assign AU  = r_au_q;
    assign BD  = r_bd_q;
    assign BU  = r_bu_q;
    assign err = r_err_q;

    // Output character mux; drives 0x00 whenever nothing is being offered.
    always_comb begin
        tx_data = 7'h00;
        if (r_state_q == S_SEND) begin
            case (r_idx_q)
                2'd0:    tx_data = r_r2_q;
                2'd1:    tx_data = r_r1_q;
                2'd2:    tx_data = r_r0_q;
                default: tx_data = c_CR;
            endcase
        end
    end

    always_comb begin
        w_state_d = r_state_q;
        w_ad_d    = r_ad_q;
        w_au_d    = r_au_q;
        w_bd_d    = r_bd_q;
        w_bu_d    = r_bu_q;
        w_r2_d    = r_r2_q;
        w_r1_d    = r_r1_q;
        w_r0_d    = r_r0_q;
        w_idx_d   = r_idx_q;
        w_err_d   = 1'b0;
        w_bad     = 1'b0;

        // Spaces are consumed without effect in every input state.
        if (w_fire && (rx_data != c_SPACE)) begin
            case (r_state_q)
                S_A0: begin
                    if (w_is_digit) begin
                        w_ad_d    = c_ZERO;
                        w_au_d    = rx_data;
                        w_state_d = S_A1;
                    end else begin
                        w_bad = 1'b1;
                    end
                end
                S_A1: begin
                    if (w_is_digit) begin
                        w_ad_d    = r_au_q;
                        w_au_d    = rx_data;
                        w_state_d = S_A2;
                    end else if (rx_data == c_PLUS) begin
                        w_state_d = S_B0;
                    end else begin
                        w_bad = 1'b1;
                    end
                end
                S_A2: begin
                    if (rx_data == c_PLUS) w_state_d = S_B0;
                    else                   w_bad     = 1'b1;
                end
                S_B0: begin
                    if (w_is_digit) begin
                        w_bd_d    = c_ZERO;
                        w_bu_d    = rx_data;
                        w_state_d = S_B1;
                    end else begin
                        w_bad = 1'b1;
                    end
                end
                S_B1: begin
                    if (w_is_digit) begin
                        w_bd_d    = r_bu_q;
                        w_bu_d    = rx_data;
                        w_state_d = S_B2;
                    end else if (rx_data == c_EQ) begin
                        w_state_d = S_LATCH;
                    end else begin
                        w_bad = 1'b1;
                    end
                end
                S_B2: begin
                    if (rx_data == c_EQ) w_state_d = S_LATCH;
                    else                 w_bad     = 1'b1;
                end
                default: ;
            endcase
        end

        // The adder has had the operands stable since the last B digit,
        // so its result is sampled exactly once here.
        if (r_state_q == S_LATCH) begin
            w_r2_d    = YC;
            w_r1_d    = YD;
            w_r0_d    = YU;
            w_idx_d   = 2'd0;
            w_state_d = S_SEND;
        end

        if ((r_state_q == S_SEND) && tx_ready) begin
            if (r_idx_q == 2'd3) begin
                w_ad_d    = c_ZERO;
                w_au_d    = c_ZERO;
                w_bd_d    = c_ZERO;
                w_bu_d    = c_ZERO;
                w_state_d = S_A0;
            end else begin
                w_idx_d = r_idx_q + 2'd1;
            end
        end

        if (w_bad) begin
            w_ad_d    = c_ZERO;
            w_au_d    = c_ZERO;
            w_bd_d    = c_ZERO;
            w_bu_d    = c_ZERO;
            w_state_d = S_A0;
            w_err_d   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= S_A0;
            r_ad_q    <= c_ZERO;
            r_au_q    <= c_ZERO;
            r_bd_q    <= c_ZERO;
            r_bu_q    <= c_ZERO;
            r_r2_q    <= c_ZERO;
            r_r1_q    <= c_ZERO;
            r_r0_q    <= c_ZERO;
            r_idx_q   <= 2'd0;
            r_err_q   <= 1'b0;
        end else begin
            r_state_q <= w_state_d;
            r_ad_q    <= w_ad_d;
            r_au_q    <= w_au_d;
            r_bd_q    <= w_bd_d;
            r_bu_q    <= w_bu_d;
            r_r2_q    <= w_r2_d;
            r_r1_q    <= w_r1_d;
            r_r0_q    <= w_r0_d;
            r_idx_q   <= w_idx_d;
            r_err_q   <= w_err_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ascii_sum_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ascii_sum_sequencer
//  Description : Self-checking bench for ascii_sum_sequencer. Provides an
//                arithmetic adder stub and an integer-valued parser model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ascii_sum_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic [6:0] AD, AU, BD, BU;
    logic [6:0] YC, YD, YU;
    logic [6:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       err;

    int n_checks = 0;
    int n_fail   = 0;

    // Parser model: operands kept as integers.
    int m_phase, m_a, m_an, m_b, m_bn;

    always #5 clk = ~clk;

    ascii_sum_sequencer dut (
        .clk(clk), .rst(rst),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .AD(AD), .AU(AU), .BD(BD), .BU(BU),
        .YC(YC), .YD(YD), .YU(YU),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .err(err)
    );

    // Adder stub: plain decimal arithmetic on the ASCII operand digits.
    int add_sum;
    always_comb begin
        add_sum = (int'(AD) - 48) * 10 + (int'(AU) - 48)
                + (int'(BD) - 48) * 10 + (int'(BU) - 48);
        YC = 7'(48 + add_sum / 100);
        YD = 7'(48 + (add_sum / 10) % 10);
        YU = 7'(48 + add_sum % 10);
    end

    function automatic void model_clear();
        m_phase = 0; m_a = 0; m_an = 0; m_b = 0; m_bn = 0;
    endfunction

    // Returns 0 = consumed, 1 = syntax error, 2 = expression complete.
    function automatic int model_step(input logic [6:0] c);
        bit is_d = (c >= 7'h30) && (c <= 7'h39);
        int d    = int'(c) - 48;
        if (c == 7'h20) return 0;
        if (m_phase == 0) begin
            if (is_d && m_an < 2) begin m_a = m_a * 10 + d; m_an++; return 0; end
            if (c == 7'h2B && m_an > 0) begin m_phase = 1; return 0; end
        end else begin
            if (is_d && m_bn < 2) begin m_b = m_b * 10 + d; m_bn++; return 0; end
            if (c == 7'h3D && m_bn > 0) return 2;
        end
        model_clear();
        return 1;
    endfunction

    task automatic send_char(input logic [6:0] c, output bit ok);
        int waitc = 0;
        ok = 1'b1;
        @(negedge clk);
        while (rx_ready !== 1'b1 && waitc < 50) begin
            @(negedge clk);
            waitc++;
        end
        n_checks++;
        if (rx_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rx_ready_timeout: got %b required 1", rx_ready);
            ok = 1'b0;
            return;
        end
        rx_data  = c;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    // mode 0: plain, 1: backpressure at idx 1, 2: reset at idx 2.
    task automatic run_frame(input string s, input int mode);
        bit          ok;
        byte         b;
        logic [6:0]  c;
        int          r, sum;
        logic [27:0] exp_ops;
        logic [6:0]  exp_c [4];
        for (int i = 0; i < s.len(); i++) begin
            b = s[i];
            c = b[6:0];
            send_char(c, ok);
            if (!ok) return;
            r = model_step(c);
            exp_ops = {7'(48 + m_a / 10), 7'(48 + m_a % 10),
                       7'(48 + m_b / 10), 7'(48 + m_b % 10)};
            n_checks++;
            if (err !== (r == 1)) begin
                n_fail++;
                $display("FAIL err_after_char '%s' pos %0d: got %b required %b", s, i, err, (r == 1));
            end
            n_checks++;
            if ({AD, AU, BD, BU} !== exp_ops) begin
                n_fail++;
                $display("FAIL operands '%s' pos %0d: got %h required %h", s, i, {AD, AU, BD, BU}, exp_ops);
            end
            if (r == 2) begin
                n_checks++;
                if (tx_valid !== 1'b0 || rx_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL latch_cycle '%s': got tx_valid=%b rx_ready=%b required 0 0", s, tx_valid, rx_ready);
                end
                sum = m_a + m_b;
                exp_c[0] = 7'(48 + sum / 100);
                exp_c[1] = 7'(48 + (sum / 10) % 10);
                exp_c[2] = 7'(48 + sum % 10);
                exp_c[3] = 7'h0D;
                @(posedge clk);
                #1;
                for (int k = 0; k < 4; k++) begin
                    if (mode == 1 && k == 1) begin
                        tx_ready = 1'b0;
                        for (int j = 0; j < 3; j++) begin
                            n_checks++;
                            if ({tx_valid, tx_data, rx_ready} !== {1'b1, exp_c[1], 1'b0}) begin
                                n_fail++;
                                $display("FAIL backpressure_hold %0d: got v=%b d=%h rdy=%b required v=1 d=%h rdy=0",
                                         j, tx_valid, tx_data, rx_ready, exp_c[1]);
                            end
                            rx_data  = 7'h35;
                            rx_valid = 1'b1;
                            @(posedge clk);
                            #1;
                        end
                        rx_valid = 1'b0;
                        tx_ready = 1'b1;
                    end
                    if (mode == 2 && k == 2) begin
                        rst = 1'b1;
                        @(posedge clk);
                        #1;
                        rst = 1'b0;
                        n_checks++;
                        if ({tx_valid, rx_ready, err, AD, AU, BD, BU} !== {3'b010, {4{7'h30}}}) begin
                            n_fail++;
                            $display("FAIL reset_mid_send: got v=%b rdy=%b err=%b ops=%h required v=0 rdy=1 err=0 ops=30303030",
                                     tx_valid, rx_ready, err, {AD, AU, BD, BU});
                        end
                        model_clear();
                        return;
                    end
                    n_checks++;
                    if ({tx_valid, tx_data, err} !== {1'b1, exp_c[k], 1'b0}) begin
                        n_fail++;
                        $display("FAIL tx_char '%s' idx %0d: got v=%b d=%h err=%b required v=1 d=%h err=0",
                                 s, k, tx_valid, tx_data, err, exp_c[k]);
                    end
                    @(posedge clk);
                    #1;
                end
                n_checks++;
                if ({rx_ready, tx_valid, AD, AU, BD, BU} !== {2'b10, {4{7'h30}}}) begin
                    n_fail++;
                    $display("FAIL frame_end '%s': got rdy=%b v=%b ops=%h required rdy=1 v=0 ops=30303030",
                             s, rx_ready, tx_valid, {AD, AU, BD, BU});
                end
                model_clear();
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; rx_valid = 1'b0; rx_data = 7'h00; tx_ready = 1'b1;
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        n_checks++;
        if ({rx_ready, tx_valid, tx_data, err, AD, AU, BD, BU} !== {2'b10, 7'h00, 1'b0, {4{7'h30}}}) begin
            n_fail++;
            $display("FAIL reset_state: got rdy=%b v=%b d=%h err=%b ops=%h required rdy=1 v=0 d=00 err=0 ops=30303030",
                     rx_ready, tx_valid, tx_data, err, {AD, AU, BD, BU});
        end
    endtask

    task automatic test_vectors();
        run_frame("12+34=", 0);
        run_frame("99+99=", 0);
        run_frame("7+5=", 0);
        run_frame("0 1+ 2=", 0);
    endtask

    task automatic test_errors();
        run_frame("123", 0);
        @(posedge clk);
        #1;
        n_checks++;
        if (err !== 1'b0) begin
            n_fail++;
            $display("FAIL err_single_cycle: got %b required 0", err);
        end
        run_frame("4+4=", 0);
        run_frame("+", 0);
        run_frame("5+=", 0);
        run_frame("A", 0);
        run_frame("1+1=", 0);
    endtask

    task automatic test_backpressure();
        run_frame("12+34=", 1);
    endtask

    task automatic test_reset_in_send();
        run_frame("12+34=", 2);
        run_frame("1+1=", 0);
    endtask

    task automatic test_reset_in_b1();
        run_frame("3+5", 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();
        n_checks++;
        if ({rx_ready, err, AD, AU, BD, BU} !== {2'b10, {4{7'h30}}}) begin
            n_fail++;
            $display("FAIL reset_in_b1: got rdy=%b err=%b ops=%h required rdy=1 err=0 ops=30303030",
                     rx_ready, err, {AD, AU, BD, BU});
        end
        // A leading '+' is only illegal if the parser really is back at the start.
        run_frame("+", 0);
        run_frame("6+7=", 0);
    endtask

    task automatic test_random();
        string s;
        int    na, nb;
        logic [6:0] ch;
        for (int f = 0; f < 30; f++) begin
            s  = "";
            na = $urandom_range(1, 2);
            nb = $urandom_range(1, 2);
            for (int p = 0; p < na + nb + 2; p++) begin
                if (p < na || (p > na && p <= na + nb)) ch = 7'(48 + $urandom_range(0, 9));
                else if (p == na)                        ch = 7'h2B;
                else                                     ch = 7'h3D;
                if ($urandom_range(0, 19) == 0) ch = 7'($urandom_range(32, 126));
                s = $sformatf("%s%c", s, ch);
                if ($urandom_range(0, 7) == 0) s = {s, " "};
            end
            run_frame(s, 0);
        end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_errors();
        test_backpressure();
        test_reset_in_send();
        test_reset_in_b1();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
